// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// All state, including the handshake outputs, is registered on the falling edge of Clk.
//
// state | meaning
// EMPTY | no payload held, out_valid=0, in_ready=1
// ONE   | head payload in main, out_valid=1, in_ready=1
// FULL  | head in main, next payload in skid, in_ready=0
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding equals the entry count so occupancy comes straight from the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, in_ready_q;
  logic             push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(negedge Clk) begin
    if (Rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule
